fetch_stage: RTL
================

// Module: fetch_stage
// PURPOSE
//  Instruction-fetch stage; drives the PC's control inputs (npc, npc_enn, n_stall) and consumes its pc.
//  Issues one instruction-BRAM read per PC advance, buffers returned words, hands them to decode (valid/ready).
//  Applies execute-stage redirects: loads PC, kills wrong-path fetches. Sits between PC and decode.
// PARAMETERS
//  ADDR_W      27  byte-address width; matches pc/npc
//  INSTR_W     32  instruction width
//  FIFO_DEPTH  2   fetch-buffer entries; legal >= 2 (2 = full throughput with 1-cycle BRAM)
// PORTS
//  clk           in   1        clock; the only clock
//  rst           in   1        synchronous, active-high reset
//  pc            in   ADDR_W   current PC value
//  npc           out  ADDR_W   redirect target to PC
//  npc_enn       out  1        PC loads npc (instead of pc+4) when n_stall=1
//  n_stall       out  1        PC advances this cycle
//  imem_en       out  1        BRAM read enable
//  imem_addr     out  ADDR_W-2 word address = pc[ADDR_W-1:2]
//  imem_rdata    in   INSTR_W  read data, valid exactly 1 cycle after imem_en
//  redirect_vld  in   1        execute resolved taken branch/jump
//  redirect_pc   in   ADDR_W   redirect target
//  if_valid      out  1        instruction available to decode
//  if_ready      in   1        decode accepts
//  if_instr      out  INSTR_W  instruction
//  if_pc         out  ADDR_W   address of if_instr
// BEHAVIOUR
//  - Reset: fifo empty, inflight=0; if_valid=0, if_instr=0, if_pc=0; while rst: n_stall=0, imem_en=0, npc_enn=0.
//  - deq = if_valid & if_ready. issue = !redirect_vld & (fifo_count - deq + inflight < FIFO_DEPTH).
//  - Normal: imem_en=issue, n_stall=issue, npc_enn=0, npc=don't-care (drive 0).
//  - In-flight reg: on issue capture {vld=1, pc}; next cycle imem_rdata+captured pc pushed into fifo.
//  - Latency: pc presented in cycle t with issue -> if_valid earliest at t+2 (registered fifo output).
//  - Throughput: 1 instr/cycle while if_ready=1 and no redirect.
//  - Handshake: if_instr/if_pc stable while if_valid & !if_ready; if_valid never drops without deq or redirect.
//  - Redirect (priority over everything): n_stall=1, npc_enn=1, npc=redirect_pc, imem_en=0;
//    fifo flushed and in-flight kill bit set -> the response returning next cycle is discarded;
//    if_valid=0 in the following cycle; first target instruction at if_valid 3 cycles after redirect cycle.
//  - Redirect with fifo full/ready low: same; flush wins over push and deq (deq in redirect cycle is still
//    legal to decode, but the next entry is gone).
//  - Back-to-back redirects: each flushes; only the last target is fetched.
//  - push & deq same cycle with fifo full: legal (count unchanged); push never occurs to a full fifo
//    (guaranteed by issue rule; assert in sim).
//  - pc low bits [1:0] ignored for imem_addr, passed unchanged on if_pc. Wrap at 27'h7FFFFFC -> 0 is PC's;
//    fetch passes addresses through unmodified.
//  - rst mid-operation: in-flight response and fifo contents discarded; no if_valid for 2 cycles after rst falls.
// STRUCTURE
//  - core_pkg: ADDR_W, INSTR_W constants; typedef struct packed {logic [ADDR_W-1:0] pc; logic [INSTR_W-1:0] instr;}
//    fetch_pkt_t.
//  - Sub-module fetch_fifo: FIFO_DEPTH-entry sync FIFO of fetch_pkt_t with push/pop/flush, count, registered
//    outputs.
//  - Top: issue/credit logic, in-flight reg + kill bit, PC control muxing.
// TESTING
//  1 Reset, if_ready=1, imem word[i]=32'h1000_0000+i: if_pc 0,4,8,... one per cycle from 2nd cycle after rst low,
//    no gaps.
//  2 if_ready low 5 cycles mid-stream: n_stall drops after fifo+inflight=2; no loss/dup; if_pc sequence continuous.
//  3 redirect_vld with redirect_pc=27'h100 while fifo full: npc_enn=1,n_stall=1 that cycle; next if_pc=0x100,
//    stale words never shown.
//  4 Redirects on two consecutive cycles (0x200, 0x300): only 0x300 stream appears.
//  5 rst asserted with inflight=1 and fifo count=2: all outputs at reset values next cycle; restart from pc=0.
//  6 Random if_ready/redirect, 10k cycles vs reference model: if_pc/if_instr match; never push to full fifo.

Source files
------------

// File: rtl/core_pkg.sv
// Shared fetch-path widths and the packet carried from the instruction BRAM to decode.
package core_pkg;
  localparam int ADDR_W  = 27;
  localparam int INSTR_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_pkt_t;

  function automatic logic [ADDR_W-3:0] word_addr(input logic [ADDR_W-1:0] byte_addr);
    return byte_addr[ADDR_W-1:2];
  endfunction
endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO of fetch packets with flush; head is read straight from storage registers.
module fetch_fifo
  import core_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int CW = $clog2(DEPTH + 1),
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push,
  input  fetch_pkt_t    push_pkt,
  input  logic          pop,
  output logic          valid,
  output fetch_pkt_t    head,
  output logic [CW-1:0] count
);

  fetch_pkt_t    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] cnt;
  logic          full;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    if (p == PW'(DEPTH - 1)) return '0;
    return p + 1'b1;
  endfunction

  assign full    = (cnt == CW'(DEPTH));
  assign valid   = (cnt != '0);
  assign do_pop  = pop & valid;
  assign do_push = push & (!full | do_pop);
  assign count   = cnt;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= ptr_inc(wr_ptr);
      if (do_pop)  rd_ptr <= ptr_inc(rd_ptr);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_pkt;
  end

  // Storage is not cleared on reset, so the head is masked to zero while empty.
  assign head = valid ? mem[rd_ptr] : '0;

  assert property (@(posedge clk) disable iff (rst || flush) !(push && full && !pop));

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: credit-based BRAM issue, one in-flight read, fetch buffer to decode, redirect flush.
module fetch_stage
  import core_pkg::*;
#(
  parameter int ADDR_W     = core_pkg::ADDR_W,
  parameter int INSTR_W    = core_pkg::INSTR_W,
  parameter int FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W-1:0]  npc,
  output logic               npc_enn,
  output logic               n_stall,
  output logic               imem_en,
  output logic [ADDR_W-3:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_vld,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               if_valid,
  input  logic               if_ready,
  output logic [INSTR_W-1:0] if_instr,
  output logic [ADDR_W-1:0]  if_pc
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  logic              inflight_vld_p1;
  logic              inflight_kill_p1;
  logic [ADDR_W-1:0] inflight_pc_p1;

  logic              deq;
  logic              issue;
  logic              push;
  logic [CW:0]       occupancy;
  logic [CW-1:0]     fifo_count;
  logic              fifo_valid;
  fetch_pkt_t        push_pkt;
  fetch_pkt_t        head_pkt;

  assign deq  = fifo_valid & if_ready;
  assign push = inflight_vld_p1 & ~inflight_kill_p1;

  // Credits: entries that will still be buffered after this cycle, counting the word returning now.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(push) - (CW+1)'(deq);
  assign issue     = ~rst & ~redirect_vld & (occupancy < (CW+1)'(FIFO_DEPTH));

  assign imem_en   = issue;
  assign imem_addr = pc[ADDR_W-1:2];
  assign n_stall   = ~rst & (issue | redirect_vld);
  assign npc_enn   = ~rst & redirect_vld;
  assign npc       = npc_enn ? redirect_pc : '0;

  // p0 -> p1: BRAM read outstanding; kill drops a response that crosses a redirect.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_vld_p1  <= 1'b0;
      inflight_kill_p1 <= 1'b0;
    end else begin
      inflight_vld_p1  <= issue;
      inflight_kill_p1 <= redirect_vld;
    end
  end

  always_ff @(posedge clk) begin
    if (issue) inflight_pc_p1 <= pc;
  end

  assign push_pkt = '{pc: inflight_pc_p1, instr: imem_rdata};

  // p1 -> p2: returned word buffered; flush on redirect outranks push and pop.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (redirect_vld),
    .push     (push),
    .push_pkt (push_pkt),
    .pop      (deq),
    .valid    (fifo_valid),
    .head     (head_pkt),
    .count    (fifo_count)
  );

  assign if_valid = fifo_valid;
  assign if_instr = head_pkt.instr;
  assign if_pc    = head_pkt.pc;

endmodule
